// File: rtl/rho_inv_seq.sv
// rho_inv_seq: sequential inverse of the Keccak-f[1600] rho step.
// Rotates every lane right by its rho offset, LANES_PER_CYCLE lanes per clock.
//
// Ports:
//   clk, rst_n             rising-edge clock, async active-low reset
//   in_valid / in_ready    input handshake for state_in [x][y][z]
//   out_valid / out_ready  output handshake for state_out [x][y][z]
//   busy                   high while lanes are being rotated
module rho_inv_seq #(
    parameter int LANES_PER_CYCLE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0][4:0][63:0] state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0][4:0][63:0] state_out,
    output logic                  busy
);

    localparam int         L         = LANES_PER_CYCLE;
    localparam logic [5:0] LANES     = 6'(L);
    localparam logic [5:0] NUM_LANES = 6'd25;

    if (!(L == 1 || L == 5 || L == 25)) begin : g_bad_lanes
        $error("rho_inv_seq: LANES_PER_CYCLE must be 1, 5 or 25");
    end

    // rho offsets mod 64, flattened as k = 5x + y
    localparam logic [5:0] OFF [25] = '{
        6'd0,  6'd36, 6'd3,  6'd41, 6'd18,
        6'd1,  6'd44, 6'd10, 6'd45, 6'd2,
        6'd62, 6'd6,  6'd43, 6'd15, 6'd61,
        6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
        6'd27, 6'd20, 6'd39, 6'd8,  6'd14
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0][4:0][63:0] work_q, work_d;

    logic [4:0][4:0][63:0] rot;
    logic [5:0]            grp_end;
    logic [24:0]           lane_sel;

    // Constant shift amount, so this is pure wiring.
    function automatic logic [63:0] rotr(
        input logic [63:0] v,
        input logic [5:0]  s
    );
        return 64'({v, v} >> s);
    endfunction

    always_comb begin
        rot = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                rot[x][y] = rotr(work_q[x][y], OFF[5*x+y]);
            end
        end
    end

    // Lanes cnt .. cnt+L-1 form the current group.
    assign grp_end = {1'b0, cnt_q} + LANES;

    always_comb begin
        lane_sel = '0;
        for (int k = 0; k < 25; k++) begin
            lane_sel[k] = (6'(k) >= {1'b0, cnt_q}) &&
                          (6'(k) < grp_end);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = state_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int x = 0; x < 5; x++) begin
                    for (int y = 0; y < 5; y++) begin
                        if (lane_sel[5*x+y]) begin
                            work_d[x][y] = rot[x][y];
                        end
                    end
                end
                cnt_d = cnt_q + LANES[4:0];
                if (grp_end == NUM_LANES) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // The working register doubles as the output register; it is only
    // written in IDLE and RUN, so it holds still for the whole of DONE.
    assign state_out = work_q;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_rho_inv_seq.sv
// tb_rho_inv_seq: self-checking bench for rho_inv_seq at L = 5, 1, 25.
// Reference offsets come from the Keccak (x,y) walk, not the offset table.
module tb_rho_inv_seq;

    typedef logic [4:0][4:0][63:0] st_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic iv  [3];
    logic ir  [3];
    logic ov  [3];
    logic orr [3];
    logic bz  [3];
    st_t  si  [3];
    st_t  so  [3];

    int lanes_of [3] = '{5, 1, 25};
    int n_cmp = 0;
    int n_bad = 0;
    int off_m [5][5];

    rho_inv_seq #(.LANES_PER_CYCLE(5)) u_l5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .state_in(si[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .state_out(so[0]),
        .busy(bz[0])
    );

    rho_inv_seq #(.LANES_PER_CYCLE(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .state_in(si[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .state_out(so[1]),
        .busy(bz[1])
    );

    rho_inv_seq #(.LANES_PER_CYCLE(25)) u_l25 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .state_in(si[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .state_out(so[2]),
        .busy(bz[2])
    );

    // Offsets (t+1)(t+2)/2 along the walk (x,y) -> (y, 2x+3y) from (1,0).
    function automatic void build_offsets();
        int x = 1;
        int y = 0;
        int nx;
        off_m[0][0] = 0;
        for (int t = 0; t < 24; t++) begin
            off_m[x][y] = ((t + 1) * (t + 2) / 2) % 64;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
    endfunction

    function automatic st_t rho_fwd(st_t s);
        st_t r;
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r[x][y][(z + off_m[x][y]) % 64] = s[x][y][z];
        return r;
    endfunction

    function automatic st_t rho_inv(st_t s);
        st_t r;
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r[x][y][z] = s[x][y][(z + off_m[x][y]) % 64];
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic chk_bit(string tag, logic got, logic want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic chk_int(string tag, int got, int want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic chk_state(string tag, st_t got, st_t want);
        int fx = 0;
        int fy = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (got[x][y] !== want[x][y]) begin
                    fx = x;
                    fy = y;
                end
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: lane[%0d][%0d] observed %h expected %h",
                   tag, fx, fy, got[fx][fy], want[fx][fy]);
        end
    endtask

    task automatic accept(int d, st_t st);
        int n = 0;
        @(negedge clk);
        iv[d] = 1'b1;
        si[d] = st;
        while (!ir[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_bit("in_ready_for_accept", ir[d], 1'b1);
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        si[d] = rand_state();
    endtask

    task automatic wait_out(int d, output int lat);
        lat = 0;
        while (!ov[d] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_bit("out_valid_timeout", ov[d], 1'b1);
    endtask

    task automatic xact(int d, st_t st, st_t want, string tag);
        int lat;
        accept(d, st);
        wait_out(d, lat);
        chk_int({tag, "_latency"}, lat, 25 / lanes_of[d]);
        chk_state(tag, so[d], want);
        @(posedge clk);
        #1;
        chk_bit({tag, "_drop"}, ov[d], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_t a, b, e;
        st_t q    [4];
        st_t want [4];
        int  lat, sent, got, cyc, last;

        build_offsets();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b1;
            si[d]  = '0;
        end

        // reset values
        #12;
        @(negedge clk);
        for (int d = 0; d < 3; d += 2) begin
            chk_bit("rst_in_ready", ir[d], 1'b1);
            chk_bit("rst_out_valid", ov[d], 1'b0);
            chk_bit("rst_busy", bz[d], 1'b0);
            chk_state("rst_state_out", so[d], '0);
        end

        // in_valid held across reset release
        a = rand_state();
        iv[0] = 1'b1;
        si[0] = a;
        @(negedge clk);
        chk_bit("rst_hold_busy", bz[0], 1'b0);
        rst_n = 1'b1;
        #1;
        chk_bit("rel_not_accepted", bz[0], 1'b0);
        @(posedge clk);
        #1;
        chk_bit("rel_first_edge_accept", bz[0], 1'b1);
        iv[0] = 1'b0;
        wait_out(0, lat);
        chk_int("rel_latency", lat, 5);
        chk_state("rel_result", so[0], rho_inv(a));
        @(posedge clk);
        #1;

        // single set bit in lane[1][0]
        for (int d = 0; d < 3; d++) begin
            a = '0;
            a[1][0] = 64'h1;
            e = '0;
            e[1][0] = 64'h8000_0000_0000_0000;
            xact(d, a, e, "single_bit");
        end

        // lanes with offsets 36, 62 and 0
        for (int d = 0; d < 3; d++) begin
            a = '0;
            a[0][1] = 64'h1;
            a[2][0] = 64'h1;
            a[0][0] = 64'hDEAD_BEEF_0123_4567;
            e = '0;
            e[0][1] = 64'h0000_0000_1000_0000;
            e[2][0] = 64'h4;
            e[0][0] = 64'hDEAD_BEEF_0123_4567;
            xact(d, a, e, "two_bits");
        end

        // random round trips through the forward rho model
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200; i++) begin
                a = rand_state();
                xact(d, rho_fwd(a), a, "round_trip");
            end
        end

        // backpressure with a pending input
        a = rand_state();
        b = rand_state();
        orr[0] = 1'b0;
        accept(0, a);
        wait_out(0, lat);
        chk_state("bp_first", so[0], rho_inv(a));
        iv[0] = 1'b1;
        si[0] = b;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_state("bp_hold", so[0], rho_inv(a));
            chk_bit("bp_in_ready", ir[0], 1'b0);
            chk_bit("bp_out_valid", ov[0], 1'b1);
        end
        orr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("bp_handoff_valid", ov[0], 1'b0);
        chk_bit("bp_handoff_ready", ir[0], 1'b1);
        chk_bit("bp_handoff_busy", bz[0], 1'b0);
        @(posedge clk);
        #1;
        chk_bit("bp_accept_busy", bz[0], 1'b1);
        chk_bit("bp_accept_ready", ir[0], 1'b0);
        iv[0] = 1'b0;
        si[0] = rand_state();
        wait_out(0, lat);
        chk_int("bp_second_latency", lat, 5);
        chk_state("bp_second", so[0], rho_inv(b));
        @(posedge clk);
        #1;

        // reset in the middle of RUN
        a = rand_state();
        accept(0, a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_bit("mid_rst_out_valid", ov[0], 1'b0);
        chk_bit("mid_rst_in_ready", ir[0], 1'b1);
        chk_bit("mid_rst_busy", bz[0], 1'b0);
        chk_state("mid_rst_state_out", so[0], '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("mid_rst_no_valid", ov[0], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        chk_bit("mid_rst_ready_after", ir[0], 1'b1);
        a = rand_state();
        xact(0, rho_fwd(a), a, "after_reset");

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            q[i]    = rand_state();
            want[i] = rho_inv(q[i]);
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        last = 0;
        @(negedge clk);
        iv[0] = 1'b1;
        si[0] = q[0];
        while (got < 4 && cyc < 200) begin
            if (ov[0]) begin
                chk_state("b2b_data", so[0], want[got]);
                if (got > 0) chk_int("b2b_spacing", cyc - last, 7);
                last = cyc;
                got++;
            end
            if (ir[0] && iv[0]) begin
                @(posedge clk);
                #1;
                sent++;
                if (sent < 4) si[0] = q[sent];
                else iv[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk_int("b2b_count", got, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rho_inv_seq.md
Name: rho_inv_seq

Overview:
- Sequential inverse of the Keccak-f[1600] rho step, used in the SHA-3 verification and inverse-permutation datapath.
- Accepts a full 5x5x64 state over a valid/ready handshake.
- Rotates each lane right by its rho offset mod 64, processing LANES_PER_CYCLE lanes per clock, then presents the result over a valid/ready handshake.
- out[x][y][z] = in[x][y][(z + off[x][y]) mod 64], i.e. rotr(lane, off). Applying it to a forward rho output restores the original state.

Parameters:
- LANES_PER_CYCLE, 5, lanes rotated per clock. Legal values are 1, 5 and 25; any other value is a compile-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  [4:0][4:0][63:0]  state, indexed [x][y][z]
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts the result
- state_out  output  [4:0][4:0][63:0]  inverse-rho result
- busy  output  1  high while in RUN

Behaviour:
- Offset table (off mod 64), indexed [x][y]:
  - x=0: 0, 36, 3, 41, 18
  - x=1: 1, 44, 10, 45, 2
  - x=2: 62, 6, 43, 15, 61
  - x=3: 28, 55, 25, 21, 56
  - x=4: 27, 20, 39, 8, 14
- Flattened lane index k = 5x + y.
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state): FSM = IDLE, lane counter = 0, working register = 0, in_ready = 1, out_valid = 0, busy = 0, state_out = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture state_in into the working register, clear the counter, go to RUN.
- RUN:
  - Each cycle, replace lanes k = cnt .. cnt+LANES_PER_CYCLE-1 in place with their rotr value.
  - cnt += LANES_PER_CYCLE.
  - When the last group is written, go to DONE.
  - in_ready = 0, busy = 1.
- DONE:
  - out_valid = 1; state_out = working register, stable while out_valid is 1.
  - On out_ready, go to IDLE and drop out_valid next cycle.
  - in_ready = 0 in DONE, so there is no same-cycle reload. The next accept happens at the earliest one cycle after the handoff.
- Latency:
  - Accept at edge N; out_valid rises after edge N + 25/LANES_PER_CYCLE.
  - That is 5 cycles at default, 25 at L=1, 1 at L=25.
  - Throughput is one state per 25/L + 2 cycles with out_ready held high.
- Rotation is a pure bit permutation with no arithmetic. Offset 0 (lane [0][0]) passes through unchanged.
- Inputs are ignored outside IDLE; state_in may change freely after the accept.
- out_ready while out_valid = 0 has no effect.
- Backpressure: DONE holds indefinitely and state_out does not change.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the partial result is discarded and never presented.
- in_valid asserted during reset release: it is not accepted until the first clock edge with rst_n = 1.

Test Plan:
- Reset, then single state with lane[1][0] = 64'h1 and all other lanes 0, out_ready = 1 -> lane[1][0] = 64'h8000_0000_0000_0000, all others 0, out_valid 5 cycles after accept.
- lane[0][1] = 64'h1 and lane[2][0] = 64'h1 -> lane[0][1] = 64'h0000_0000_1000_0000 (bit 28), lane[2][0] = 64'h4 (bit 2); lane[0][0] = 64'hDEAD_BEEF_0123_4567 passes unchanged.
- Round trip with 200 random states through the forward rho model, then this block, for L = 1, 5 and 25 -> output equals the original state bit-exactly; latency is 25, 5 and 1 respectively.
- Backpressure: out_ready low for 10 cycles after out_valid -> state_out stable, in_ready = 0, a new in_valid is ignored. Raise out_ready -> accept the pending input 1 cycle after handoff.
- Assert rst_n = 0 during RUN at cycle 2 of 5 -> out_valid stays 0, in_ready = 1 right after reset, a fresh state then completes correctly.
- Back-to-back stream of 4 states with in_valid and out_ready held high -> 4 correct results, spaced 7 cycles apart at default L.
